// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver. Scans one digit per DIV-cycle slot.
// Loads are double-buffered so the displayed value only changes on frame boundaries.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIV        = 1000,
  parameter bit          HEX_MODE   = 1'b0,
  parameter bit          BLANK_LEAD = 1'b1,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_enable,
  input  logic                      i_load,
  input  logic [4*NUM_DIGITS-1:0]   i_value,
  input  logic [NUM_DIGITS-1:0]     i_dp_in,
  output logic [6:0]                o_seg,
  output logic                      o_dp,
  output logic [NUM_DIGITS-1:0]     o_an,
  output logic                      o_frame_done
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PreW = $clog2(DIV);

  localparam logic [IdxW-1:0]       LastIdx = IdxW'(NUM_DIGITS - 1);
  localparam logic [PreW-1:0]       LastPre = PreW'(DIV - 1);
  localparam logic [NUM_DIGITS-1:0] AnOne   = NUM_DIGITS'(1);

  // Physical "off" levels; XOR-ing with these applies the board polarity.
  localparam logic [6:0]            SegOff  = {7{ACTIVE_LOW}};
  localparam logic                  DpOff   = ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AnOff   = {NUM_DIGITS{ACTIVE_LOW}};

  logic [PreW-1:0]         r_presc;
  logic [IdxW-1:0]         r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend;
  logic [4*NUM_DIGITS-1:0] r_act_val;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_done;

  logic                    w_tick;
  logic                    w_boundary;
  logic [PreW-1:0]         w_presc_nxt;
  logic [IdxW-1:0]         w_idx_nxt;
  logic [4*NUM_DIGITS-1:0] w_pend_val_nxt;
  logic [NUM_DIGITS-1:0]   w_pend_dp_nxt;
  logic                    w_pend_nxt;
  logic [4*NUM_DIGITS-1:0] w_act_val_nxt;
  logic [NUM_DIGITS-1:0]   w_act_dp_nxt;
  logic [3:0]              w_digit;
  logic                    w_digit_dp;
  logic                    w_blank;
  logic [6:0]              w_seg_nxt;
  logic                    w_dp_nxt;
  logic [NUM_DIGITS-1:0]   w_an_nxt;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    logic [6:0] s;
    s = 7'b0000000;
    case (d)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = HEX_MODE ? 7'b1110111 : 7'b0000000;
      4'hB: s = HEX_MODE ? 7'b0011111 : 7'b0000000;
      4'hC: s = HEX_MODE ? 7'b1001110 : 7'b0000000;
      4'hD: s = HEX_MODE ? 7'b0111101 : 7'b0000000;
      4'hE: s = HEX_MODE ? 7'b1001111 : 7'b0000000;
      4'hF: s = HEX_MODE ? 7'b1000111 : 7'b0000000;
    endcase
    return s;
  endfunction

  assign w_tick     = i_enable && (r_presc == LastPre);
  assign w_boundary = w_tick && (r_idx == LastIdx);

  // Scan timing: prescaler and digit index both freeze while disabled.
  always_comb begin
    w_presc_nxt = r_presc;
    w_idx_nxt   = r_idx;
    if (i_enable) begin
      w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        w_idx_nxt = (r_idx == LastIdx) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Double buffer: a load on the boundary cycle bypasses pending entirely.
  always_comb begin
    w_pend_val_nxt = r_pend_val;
    w_pend_dp_nxt  = r_pend_dp;
    w_pend_nxt     = r_pend;
    w_act_val_nxt  = r_act_val;
    w_act_dp_nxt   = r_act_dp;
    if (i_load) begin
      w_pend_val_nxt = i_value;
      w_pend_dp_nxt  = i_dp_in;
      w_pend_nxt     = 1'b1;
    end
    if (w_boundary) begin
      if (i_load) begin
        w_act_val_nxt = i_value;
        w_act_dp_nxt  = i_dp_in;
        w_pend_nxt    = 1'b0;
      end else if (r_pend) begin
        w_act_val_nxt = r_pend_val;
        w_act_dp_nxt  = r_pend_dp;
        w_pend_nxt    = 1'b0;
      end
    end
  end

  // Leading blank: this digit and everything above it are zero.
  always_comb begin
    w_digit    = 4'h0;
    w_digit_dp = 1'b0;
    w_blank    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IdxW'(i)) begin
        w_digit    = r_act_val[4*i +: 4];
        w_digit_dp = r_act_dp[i];
        w_blank    = BLANK_LEAD && (i != 0) && ((r_act_val >> (4*i)) == '0);
      end
    end
  end

  always_comb begin
    w_seg_nxt = SegOff;
    w_dp_nxt  = DpOff;
    w_an_nxt  = AnOff;
    if (i_enable) begin
      w_seg_nxt = (w_blank ? 7'b0000000 : f_decode(w_digit)) ^ SegOff;
      w_dp_nxt  = w_digit_dp ^ DpOff;
      w_an_nxt  = (AnOne << r_idx) ^ AnOff;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend       <= 1'b0;
      r_act_val    <= '0;
      r_act_dp     <= '0;
      r_seg        <= SegOff;
      r_dp         <= DpOff;
      r_an         <= AnOff;
      r_frame_done <= 1'b0;
    end else begin
      r_presc      <= w_presc_nxt;
      r_idx        <= w_idx_nxt;
      r_pend_val   <= w_pend_val_nxt;
      r_pend_dp    <= w_pend_dp_nxt;
      r_pend       <= w_pend_nxt;
      r_act_val    <= w_act_val_nxt;
      r_act_dp     <= w_act_dp_nxt;
      r_seg        <= w_seg_nxt;
      r_dp         <= w_dp_nxt;
      r_an         <= w_an_nxt;
      r_frame_done <= w_boundary;
    end
  end

  assign o_seg        = r_seg;
  assign o_dp         = r_dp;
  assign o_an         = r_an;
  assign o_frame_done = r_frame_done;

endmodule
